uart_rcvr: RTL and testbench

Serial receive engine for the soda-machine UART, the receive-side counterpart of the transmitter. It oversamples `RxD` at 16x baud using the shared baud generator's sample tick, and deframes start, 7/8 data, optional parity and 1/2 stop bits. It emits one 10-bit word per character, `{fe, pe, data[7:0]}`, with a single-cycle done strobe, ready to be written directly into the RX FIFO by the top level.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/rx_sync.sv | 36 +++
 rtl/uart_rcvr.sv | 161 ++++++++++++++++
 tb/tb_uart_rcvr.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, parity codes and data-word layout.
// The transmitter uses the same parity codes and field positions.
package uart_pkg;

   localparam int unsigned OSR_DEFAULT = 16;

   localparam logic [1:0] PAR_NONE = 2'b00;
   localparam logic [1:0] PAR_ODD  = 2'b01;
   localparam logic [1:0] PAR_EVEN = 2'b10;

   localparam int unsigned FE_BIT = 9;
   localparam int unsigned PE_BIT = 8;

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StParity,
      StStop,
      StStop2
   } rx_state_e;

   // Code 2'b11 is reserved and behaves as no parity.
   function automatic logic par_enabled(input logic [1:0] p);
      return (p == PAR_ODD) || (p == PAR_EVEN);
   endfunction

endpackage

// File: rtl/rx_sync.sv
// Two-flop synchronizer for the serial line followed by a falling-edge detector.
// All flops preset to 1 so the idle-high line never produces a spurious edge out of reset.
module rx_sync (
   input  logic clk,
   input  logic n_rst,
   input  logic rxd,
   output logic rxd_s,
   output logic rxd_fall
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;
   logic prev_q, prev_d;

   always_comb begin
      meta_d = rxd;
      sync_d = meta_q;
      prev_d = sync_q;
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
         prev_q <= 1'b1;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign rxd_s    = sync_q;
   assign rxd_fall = prev_q & ~sync_q;

endmodule

// File: rtl/uart_rcvr.sv
// UART receive engine: oversampled deframing of start, 7/8 data, optional parity and 1/2 stop
// bits into a {fe, pe, data} word with a one-cycle done strobe.
module uart_rcvr
   import uart_pkg::*;
#(
   parameter int unsigned OSR = OSR_DEFAULT
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic       RxD,
   input  logic       sample_tick,
   input  logic       d_num,
   input  logic       s_num,
   input  logic [1:0] par,
   output logic [9:0] Rx_Dout,
   output logic       Rx_Done,
   output logic       Rx_Busy
);

   localparam logic [3:0] MidTick  = 4'(OSR / 2 - 1);
   localparam logic [3:0] LastTick = 4'(OSR - 1);

   logic rxd_s, rxd_fall;

   rx_sync u_rx_sync (
      .clk      (clk),
      .n_rst    (n_rst),
      .rxd      (RxD),
      .rxd_s    (rxd_s),
      .rxd_fall (rxd_fall)
   );

   rx_state_e   state_q, state_d;
   logic [3:0]  tick_q, tick_d;
   logic [2:0]  bit_q, bit_d;
   logic [7:0]  shift_q, shift_d;
   logic        fe_q, fe_d;
   logic        pe_q, pe_d;
   logic        d_num_q, d_num_d;
   logic        s_num_q, s_num_d;
   logic [1:0]  par_q, par_d;
   logic [9:0]  dout_q, dout_d;
   logic        done_q, done_d;

   logic [7:0]  data_w;
   logic        exp_par;
   logic        fe_now;
   logic        tick_last;

   // In 7-bit mode the bits land in [7:1] of the right-shifting register.
   assign data_w    = d_num_q ? shift_q : {1'b0, shift_q[7:1]};
   assign exp_par   = (par_q == PAR_ODD) ? ~(^data_w) : (^data_w);
   assign tick_last = sample_tick && (tick_q == LastTick);

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q <= StIdle;
         tick_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         fe_q    <= 1'b0;
         pe_q    <= 1'b0;
         d_num_q <= 1'b0;
         s_num_q <= 1'b0;
         par_q   <= PAR_NONE;
         dout_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         tick_q  <= tick_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         fe_q    <= fe_d;
         pe_q    <= pe_d;
         d_num_q <= d_num_d;
         s_num_q <= s_num_d;
         par_q   <= par_d;
         dout_q  <= dout_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      tick_d  = tick_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      fe_d    = fe_q;
      pe_d    = pe_q;
      d_num_d = d_num_q;
      s_num_d = s_num_q;
      par_d   = par_q;
      dout_d  = dout_q;
      done_d  = 1'b0;
      fe_now  = fe_q | ~rxd_s;

      if (sample_tick && state_q != StIdle) begin
         tick_d = (tick_q == LastTick) ? 4'd0 : tick_q + 4'd1;
      end

      unique case (state_q)
         StIdle: begin
            if (rxd_fall) begin
               tick_d  = '0;
               state_d = StStart;
            end
         end
         StStart: begin
            if (sample_tick && tick_q == MidTick) begin
               if (!rxd_s) begin
                  d_num_d = d_num;
                  s_num_d = s_num;
                  par_d   = par;
                  tick_d  = '0;
                  bit_d   = '0;
                  fe_d    = 1'b0;
                  pe_d    = 1'b0;
                  state_d = StData;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         StData: begin
            if (tick_last) begin
               shift_d = {rxd_s, shift_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == (d_num_q ? 3'd7 : 3'd6)) begin
                  state_d = par_enabled(par_q) ? StParity : StStop;
               end
            end
         end
         StParity: begin
            if (tick_last) begin
               pe_d    = rxd_s ^ exp_par;
               state_d = StStop;
            end
         end
         StStop, StStop2: begin
            if (tick_last) begin
               fe_d = fe_now;
               if (state_q == StStop && s_num_q) begin
                  state_d = StStop2;
               end else begin
                  dout_d  = {fe_now, pe_q, data_w};
                  done_d  = 1'b1;
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      Rx_Dout = dout_q;
      Rx_Done = done_q;
      Rx_Busy = (state_q != StIdle);
   end

endmodule

// File: tb/tb_uart_rcvr.sv
// Scoreboard bench for uart_rcvr: frames are driven bit-serially, expected words are queued
// from a reference model and a monitor pops them on every Rx_Done.
module tb_uart_rcvr;

   localparam int TickClk = 27;
   localparam int BitClk  = 16 * TickClk;

   logic       clk = 1'b0;
   logic       n_rst;
   logic       RxD;
   logic       sample_tick;
   logic       d_num;
   logic       s_num;
   logic [1:0] par;
   logic [9:0] Rx_Dout;
   logic       Rx_Done;
   logic       Rx_Busy;

   int checks = 0;
   int errors = 0;
   logic [9:0] exp_q[$];
   bit busy_chk = 1'b0;

   uart_rcvr dut (
      .clk         (clk),
      .n_rst       (n_rst),
      .RxD         (RxD),
      .sample_tick (sample_tick),
      .d_num       (d_num),
      .s_num       (s_num),
      .par         (par),
      .Rx_Dout     (Rx_Dout),
      .Rx_Done     (Rx_Done),
      .Rx_Busy     (Rx_Busy)
   );

   always #10 clk = ~clk;

   initial begin
      sample_tick = 1'b0;
      forever begin
         repeat (TickClk - 1) @(negedge clk);
         sample_tick = 1'b1;
         @(negedge clk);
         sample_tick = 1'b0;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: word built straight from the frame contents.
   function automatic logic [9:0] model(input logic [7:0] data, input bit d8, input logic [1:0] pr,
                                        input bit pbit, input bit st1, input bit st2, input bit s2);
      logic [7:0] d;
      bit pe, fe;
      int ones;
      d    = d8 ? data : {1'b0, data[6:0]};
      ones = $countones(d);
      pe   = 1'b0;
      if (pr == 2'b01) pe = (pbit != ((ones % 2) == 0));
      else if (pr == 2'b10) pe = (pbit != ((ones % 2) == 1));
      fe = !st1 || (s2 && !st2);
      return {fe, pe, d};
   endfunction

   always @(negedge clk) begin
      if (busy_chk) begin
         check("busy_after_done", {31'd0, Rx_Busy}, 32'd0);
         busy_chk = 1'b0;
      end
      if (Rx_Done) begin
         busy_chk = 1'b1;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got Rx_Dout 0x%0h, expected no Rx_Done", Rx_Dout);
         end else begin
            check("rx_dout", {22'd0, Rx_Dout}, {22'd0, exp_q.pop_front()});
         end
      end
   end

   task automatic drive_bit(input bit b);
      RxD = b;
      repeat (BitClk) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] data, input bit d8, input logic [1:0] pr,
                             input bit pbit, input bit st1, input bit st2, input bit s2,
                             input bit scramble);
      d_num = d8;
      s_num = s2;
      par   = pr;
      exp_q.push_back(model(data, d8, pr, pbit, st1, st2, s2));
      drive_bit(1'b0);
      for (int i = 0; i < (d8 ? 8 : 7); i++) begin
         drive_bit(data[i]);
         if (scramble && i == 1) begin
            d_num = 1'($urandom);
            s_num = 1'($urandom);
            par   = 2'($urandom);
         end
      end
      if (pr == 2'b01 || pr == 2'b10) drive_bit(pbit);
      drive_bit(st1);
      if (s2) drive_bit(st2);
      drive_bit(1'b1);
   endtask

   task automatic wait_drain(input string name);
      for (int i = 0; i < 4 * BitClk && exp_q.size() != 0; i++) @(negedge clk);
      check(name, exp_q.size(), 0);
      exp_q.delete();
   endtask

   initial begin
      logic [7:0] rd;
      n_rst = 1'b0;
      RxD   = 1'b1;
      d_num = 1'b1;
      s_num = 1'b0;
      par   = 2'b00;
      repeat (3) @(negedge clk);
      check("reset_dout", {22'd0, Rx_Dout}, 32'd0);
      check("reset_done", {31'd0, Rx_Done}, 32'd0);
      check("reset_busy", {31'd0, Rx_Busy}, 32'd0);
      n_rst = 1'b1;
      repeat (BitClk) @(negedge clk);

      // 8N1 0xA5
      send_frame(8'hA5, 1, 2'b00, 0, 1, 1, 0, 0);
      wait_drain("drain_8n1");
      // 7E1 0x41, wrong then correct parity
      send_frame(8'h41, 0, 2'b10, 1, 1, 1, 0, 0);
      send_frame(8'h41, 0, 2'b10, 0, 1, 1, 0, 0);
      wait_drain("drain_7e1");
      // 8O2 0x3C, bad second stop then good
      send_frame(8'h3C, 1, 2'b01, 1, 1, 0, 1, 0);
      send_frame(8'h3C, 1, 2'b01, 1, 1, 1, 1, 0);
      wait_drain("drain_8o2");

      // Glitch: low for 4 ticks
      d_num = 1'b1; s_num = 1'b0; par = 2'b00;
      RxD = 1'b0;
      repeat (2 * TickClk) @(negedge clk);
      check("glitch_busy_high", {31'd0, Rx_Busy}, 32'd1);
      repeat (2 * TickClk) @(negedge clk);
      RxD = 1'b1;
      repeat (6 * TickClk) @(negedge clk);
      check("glitch_busy_low", {31'd0, Rx_Busy}, 32'd0);
      repeat (BitClk) @(negedge clk);
      send_frame(8'h55, 1, 2'b00, 0, 1, 1, 0, 0);
      wait_drain("drain_glitch");

      // Break: 20 bit times low, single framing-error word
      d_num = 1'b1; s_num = 1'b0; par = 2'b00;
      exp_q.push_back(10'h200);
      for (int i = 0; i < 20; i++) drive_bit(1'b0);
      wait_drain("drain_break");
      drive_bit(1'b1);
      drive_bit(1'b1);
      rd = 8'($urandom);
      send_frame(rd, 1, 2'b00, 0, 1, 1, 0, 0);
      wait_drain("drain_after_break");

      // Reset during data bit 3 of 0xC3
      d_num = 1'b1; s_num = 1'b0; par = 2'b00;
      drive_bit(1'b0);
      drive_bit(1'b1);
      drive_bit(1'b1);
      drive_bit(1'b0);
      RxD = 1'b0;
      repeat (BitClk / 2) @(negedge clk);
      n_rst = 1'b0;
      #1;
      check("midreset_done", {31'd0, Rx_Done}, 32'd0);
      check("midreset_dout", {22'd0, Rx_Dout}, 32'd0);
      check("midreset_busy", {31'd0, Rx_Busy}, 32'd0);
      RxD = 1'b1;
      repeat (5) @(negedge clk);
      n_rst = 1'b1;
      repeat (BitClk) @(negedge clk);
      send_frame(8'hC3, 1, 2'b00, 0, 1, 1, 0, 0);
      wait_drain("drain_midreset");

      // Random frames, config scrambled mid-frame
      for (int n = 0; n < 4; n++) begin
         send_frame(8'($urandom), 1'($urandom), 2'($urandom), 1'($urandom),
                    $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, 1'($urandom), 1);
         wait_drain("drain_random");
      end

      repeat (10) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
